// File: rtl/serial_nibble_loader_pkg.sv
// Shared constants and types for the serial nibble loader: frame levels,
// default word width and the deframer state encoding.
package serial_nibble_loader_pkg;

  localparam int DEF_DATA_W = 4;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    DATA = ST_DATA,
    STOP = ST_STOP
  } state_e;

endpackage

// File: rtl/serial_nibble_loader_if.sv
// Serial-side inputs and register-side outputs of the loader; master drives
// the line and tick, slave (the loader) drives the parallel word and strobes.
interface serial_nibble_loader_if
  import serial_nibble_loader_pkg::*;
  #(parameter int DATA_W = DEF_DATA_W) ();

  logic              BitTick;
  logic              SerIn;
  logic [DATA_W-1:0] D;
  logic              Load;
  logic              FrameErr;
  logic              Busy;

  modport master (
    output BitTick, SerIn,
    input  D, Load, FrameErr, Busy
  );

  modport slave (
    input  BitTick, SerIn,
    output D, Load, FrameErr, Busy
  );

endinterface

// File: rtl/serial_nibble_loader_sipo_shift_reg.sv
// Serial-in/parallel-out shifter, new bits enter at the MSB so LSB-first data lands in place.
// Latency: one clk per shift; no backpressure, shifts whenever shift_en_i is high.
module sipo_shift_reg
  import serial_nibble_loader_pkg::*;
  #(parameter int DATA_W = DEF_DATA_W) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              shift_en_i,
  input  logic              ser_i,
  output logic [DATA_W-1:0] par_o
);

  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;

  generate
    if (DATA_W == 1) begin : g_single
      assign shreg_d = shift_en_i ? ser_i : shreg_q;
    end else begin : g_multi
      assign shreg_d = shift_en_i ? {ser_i, shreg_q[DATA_W-1:1]} : shreg_q;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign par_o = shreg_q;

endmodule

// File: rtl/serial_nibble_loader.sv
// Deframes start/data/stop serial frames into a parallel word with a one-cycle Load strobe.
// Latency: DATA_W+2 ticks plus one clk to Load; no backpressure, bad frames raise FrameErr.
module serial_nibble_loader
  import serial_nibble_loader_pkg::*;
  #(parameter int DATA_W = DEF_DATA_W) (
  input  logic                  Clk,
  input  logic                  Reset,
  serial_nibble_loader_if.slave bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic              load_q, load_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;
  logic              shift_en;
  logic [DATA_W-1:0] shreg;

  sipo_shift_reg #(.DATA_W(DATA_W)) u_sipo (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .shift_en_i (shift_en),
    .ser_i      (bus.SerIn),
    .par_o      (shreg)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    load_d   = 1'b0;
    ferr_d   = 1'b0;
    shift_en = 1'b0;
    if (bus.BitTick) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.SerIn == START_BIT) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end
        ST_DATA: begin
          shift_en = 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_d = ST_STOP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          // A low stop bit ends the frame; it is never taken as the next start bit.
          if (bus.SerIn == STOP_BIT) begin
            d_d    = shreg;
            load_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      load_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      load_q  <= load_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.D        = d_q;
  assign bus.Load     = load_q;
  assign bus.FrameErr = ferr_q;
  assign bus.Busy     = busy_q;

endmodule

// File: tb/tb_serial_nibble_loader.sv
// Bench for serial_nibble_loader: hand-written vector table, directed corner
// sequences and random traffic against a queue-based frame model.
module tb_serial_nibble_loader;
  import serial_nibble_loader_pkg::*;

  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  serial_nibble_loader_if #(.DATA_W(DW)) bus ();

  serial_nibble_loader #(.DATA_W(DW)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a start bit, DW collected bits, then the stop bit.
  logic          m_busy = 1'b0;
  logic          m_load = 1'b0;
  logic          m_ferr = 1'b0;
  logic [DW-1:0] m_d = '0;
  bit            m_bits[$];

  int            load_cyc[$];
  logic [DW-1:0] load_val[$];

  typedef struct {
    logic       rst;
    logic       tick;
    logic       ser;
    logic [6:0] exp;  // {Busy, Load, FrameErr, D}
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic r, input logic t, input logic s,
                              input logic b, input logic l, input logic f,
                              input logic [3:0] d);
    vec_t v;
    v.rst = r; v.tick = t; v.ser = s; v.exp = {b, l, f, d};
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic void model_step(input logic r, input logic t, input logic s);
    int w;
    m_load = 1'b0;
    m_ferr = 1'b0;
    if (r) begin
      m_busy = 1'b0;
      m_bits.delete();
      m_d = '0;
    end else if (t) begin
      if (!m_busy) begin
        if (s == 1'b0) begin
          m_busy = 1'b1;
          m_bits.delete();
        end
      end else if (m_bits.size() < DW) begin
        m_bits.push_back(s);
      end else begin
        if (s) begin
          w = 0;
          for (int i = 0; i < DW; i++) w += int'(m_bits[i]) << i;
          m_d = DW'(w);
          m_load = 1'b1;
        end else begin
          m_ferr = 1'b1;
        end
        m_busy = 1'b0;
      end
    end
  endfunction

  task automatic cycle(input logic r, input logic t, input logic s);
    rst = r;
    bus.BitTick = t;
    bus.SerIn = s;
    @(posedge clk);
    cyc++;
    model_step(r, t, s);
    @(negedge clk);
    check("model", {25'd0, bus.Busy, bus.Load, bus.FrameErr, bus.D},
          {25'd0, m_busy, m_load, m_ferr, m_d});
    if (bus.Load) begin
      load_cyc.push_back(cyc);
      load_val.push_back(bus.D);
    end
  endtask

  task automatic send_frame(input logic [3:0] w, input logic stop, input int gap);
    logic b;
    for (int i = 0; i < DW + 2; i++) begin
      b = (i == 0) ? 1'b0 : (i == DW + 1) ? stop : w[i-1];
      cycle(1'b0, 1'b1, b);
      for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, (g == 0) ? ~b : b);
    end
  endtask

  initial begin
    bus.BitTick = 1'b0;
    bus.SerIn = 1'b1;

    add(1, 0, 1, 0, 0, 0, 4'h0);
    for (int i = 0; i < 8; i++) add(0, 1, 1, 0, 0, 0, 4'h0);
    add(0, 1, 0, 1, 0, 0, 4'h0);
    add(0, 1, 0, 1, 0, 0, 4'h0);
    add(0, 1, 1, 1, 0, 0, 4'h0);
    add(0, 1, 0, 1, 0, 0, 4'h0);
    add(0, 1, 1, 1, 0, 0, 4'h0);
    add(0, 1, 1, 0, 1, 0, 4'hA);
    add(0, 0, 0, 0, 0, 0, 4'hA);
    add(0, 1, 0, 1, 0, 0, 4'hA);
    add(0, 1, 1, 1, 0, 0, 4'hA);
    add(0, 1, 0, 1, 0, 0, 4'hA);
    add(0, 1, 1, 1, 0, 0, 4'hA);
    add(0, 1, 0, 1, 0, 0, 4'hA);
    add(0, 1, 0, 0, 0, 1, 4'hA);
    add(0, 1, 1, 0, 0, 0, 4'hA);
    add(0, 0, 0, 0, 0, 0, 4'hA);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rst, tbl[i].tick, tbl[i].ser);
      check($sformatf("table[%0d]", i),
            {25'd0, bus.Busy, bus.Load, bus.FrameErr, bus.D}, {25'd0, tbl[i].exp});
    end

    // Back-to-back frames with the tick held high.
    load_cyc.delete(); load_val.delete();
    send_frame(4'h3, 1'b1, 0);
    send_frame(4'hC, 1'b1, 0);
    cycle(0, 0, 1);
    check("b2b_load_count", load_cyc.size(), 2);
    if (load_cyc.size() == 2) begin
      check("b2b_spacing", load_cyc[1] - load_cyc[0], 6);
      check("b2b_first_d", load_val[0], 4'h3);
      check("b2b_second_d", load_val[1], 4'hC);
    end

    // Reset after the second data bit aborts the frame.
    load_cyc.delete(); load_val.delete();
    cycle(0, 1, 0);
    cycle(0, 1, 1);
    cycle(0, 1, 1);
    cycle(1, 1, 0);
    check("rst_mid_busy", bus.Busy, 0);
    check("rst_mid_d", bus.D, 4'h0);
    check("rst_mid_no_load", load_cyc.size(), 0);
    send_frame(4'hF, 1'b1, 0);
    cycle(0, 0, 1);
    check("after_rst_d", bus.D, 4'hF);
    check("after_rst_loads", load_cyc.size(), 1);

    // Sparse ticks with the line toggling between them.
    load_cyc.delete(); load_val.delete();
    send_frame(4'h6, 1'b1, 2);
    check("sparse_d", bus.D, 4'h6);
    check("sparse_loads", load_cyc.size(), 1);
    check("sparse_busy", bus.Busy, 0);

    for (int i = 0; i < 4000; i++)
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 3) != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
